// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode, state and selector encodings for the multicycle CPU
package cpu_defs;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP   = 4'd9;
    localparam logic [3:0] ST_ADDIEX = 4'd10;
    localparam logic [3:0] ST_ADDIWB = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_MEMADR = ST_MEMADR,
        S_MEMRD  = ST_MEMRD,
        S_MEMWB  = ST_MEMWB,
        S_MEMWR  = ST_MEMWR,
        S_EXEC   = ST_EXEC,
        S_ALUWB  = ST_ALUWB,
        S_BRANCH = ST_BRANCH,
        S_JUMP   = ST_JUMP,
        S_ADDIEX = ST_ADDIEX,
        S_ADDIWB = ST_ADDIWB
    } state_t;

    // ALU-B operand mux selector
    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    // next-PC mux selector
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM stepping instructions through the multicycle datapath
module multicycle_control
    import cpu_defs::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_J     = OPC_J,
    parameter logic [5:0] OP_ADDI  = OPC_ADDI
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] State
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_REG;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                ALUSrcB    = ALUSRCB_FOUR;
                PCWrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // branch target is precomputed here so BRANCH only has to compare
                ALUSrcB = ALUSRCB_IMMSH2;
                if (Op == OP_LW || Op == OP_SW) next_state = S_MEMADR;
                else if (Op == OP_RTYPE)        next_state = S_EXEC;
                else if (Op == OP_BEQ)          next_state = S_BRANCH;
                else if (Op == OP_J)            next_state = S_JUMP;
                else if (Op == OP_ADDI)         next_state = S_ADDIEX;
                else                            next_state = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALUSRCB_IMM;
                next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALUSRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    assign PCEn  = PCWrite | (PCWriteCond & Zero);
    assign State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic       Zero;
    logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    int exp_seq[$];

    multicycle_control dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .State(State)
    );

    always #5 clk = ~clk;

    // Control word expected in each state, written straight from the state table.
    function automatic logic [16:0] exp_out(input int st, input logic z);
        logic pcw, pcwc, iord, mr, mw, irw, rw, rd, m2r, asa;
        logic [1:0] asb, pcs, aop;
        {pcw, pcwc, iord, mr, mw, irw, rw, rd, m2r, asa} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, pcw | (pcwc & z), iord, mr, mw, irw, rw, rd, m2r, asa, asb, pcs, aop};
    endfunction

    function automatic logic [16:0] observed();
        return {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp};
    endfunction

    task automatic fill_seq(input logic [5:0] op);
        exp_seq.delete();
        exp_seq.push_back(0);
        exp_seq.push_back(1);
        case (op)
            6'b100011: begin exp_seq.push_back(2); exp_seq.push_back(3); exp_seq.push_back(4); end
            6'b101011: begin exp_seq.push_back(2); exp_seq.push_back(5); end
            6'b000000: begin exp_seq.push_back(6); exp_seq.push_back(7); end
            6'b000100: exp_seq.push_back(8);
            6'b000010: exp_seq.push_back(9);
            6'b001000: begin exp_seq.push_back(10); exp_seq.push_back(11); end
            default: ;
        endcase
    endtask

    // Called at a falling edge with the machine in FETCH; zmode 0/1 forces Zero, 2 randomizes it.
    task automatic run_instr(input logic [5:0] op, input int zmode);
        fill_seq(op);
        Op = op;
        foreach (exp_seq[i]) begin
            Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            checks++;
            if (State !== 4'(exp_seq[i])) begin
                errors++;
                $display("FAIL state op=%b step=%0d got=%0d want=%0d", op, i, State, exp_seq[i]);
            end
            checks++;
            if (observed() !== exp_out(exp_seq[i], Zero)) begin
                errors++;
                $display("FAIL outputs op=%b state=%0d got=%h want=%h", op, exp_seq[i],
                         observed(), exp_out(exp_seq[i], Zero));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Op = 6'b100011; Zero = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || observed() !== exp_out(0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state got=%0d/%h want=0/%h", State, observed(), exp_out(0, 1'b0));
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold got=%0d want=0", State);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequences();
        logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000010,
                                6'b001000, 6'b111111, 6'b010101};
        foreach (ops[i]) run_instr(ops[i], 2);
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 1);
        run_instr(6'b000100, 0);
        run_instr(6'b000100, 2);
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = legal[$urandom_range(0, 5)];
            run_instr(op, 2);
        end
    endtask

    task automatic test_reset_mid_instr();
        Op = 6'b100011; Zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (State !== 4'd3) begin
            errors++;
            $display("FAIL reach_memrd got=%0d want=3", State);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0 || observed() !== exp_out(0, Zero)) begin
            errors++;
            $display("FAIL async_reset got=%0d/%h want=0/%h", State, observed(), exp_out(0, Zero));
        end
        @(posedge clk);
        #1;
        checks++;
        if (State !== 4'd0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_wb state=%0d regwrite=%b want=0/0", State, RegWrite);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL first_edge_after_reset got=%0d want=1", State);
        end
        @(negedge clk);
        Op = 6'b111111;
        @(negedge clk);
        run_instr(6'b100011, 2);
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_beq();
        test_back_to_back();
        test_reset_mid_instr();
        run_instr(6'b000000, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
